hash_multicast_arbiter: RTL and testbench

Round-robin arbiter that shares the single multicast flow-table lookup port (`ftm_req_*` / `ftm_resp_*` of the multicast hash block) between `NUM_PORTS` frame_process requesters. It grants one requester at a time and forwards its 16-bit MAC suffix to the lookup. It returns the lookup's ack/nak and 16-bit port map to the granted requester. It then drains the lookup's level handshake before the next grant. It sits in the `clk_sys` domain between the per-port frame_process instances and the multicast lookup.

---
 rtl/hash_mc_pkg.sv | 15 +
 rtl/hash_multicast_arbiter_rr.sv | 33 +++
 rtl/hash_multicast_arbiter.sv | 141 ++++++++++++++
 tb/tb_hash_multicast_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_mc_pkg.sv
// Shared types for the multicast lookup arbiter.
// One-hot FSM encodings and datapath widths.
package hash_mc_pkg;

  localparam int MAC_W = 16;
  localparam int MAP_W = 16;

  typedef enum logic [3:0] {
    ARB_IDLE  = 4'b0001,
    ARB_ISSUE = 4'b0010,
    ARB_WAIT  = 4'b0100,
    ARB_DRAIN = 4'b1000
  } arb_state_e;

endpackage

// File: rtl/hash_multicast_arbiter_rr.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
// Ports: req, ptr in; grant (one-hot), idx, any_req out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  int   c;
  logic found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    c       = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/hash_multicast_arbiter.sv
// Shares one multicast lookup port among NUM_PORTS requesters, round-robin.
// Ports: clk_sys, rst_sys (async, low); req_valid/req_mac in; resp_ack/
// resp_nak/resp_result out; ftm_req_* out; ftm_resp_* in; timeout_err out.
// Optional watchdog: define HASH_MC_ARB_TIMEOUT_EN.
module hash_multicast_arbiter
  import hash_mc_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys,
  input  logic [NUM_PORTS-1:0]   req_valid,
  input  logic [16*NUM_PORTS-1:0] req_mac,
  output logic [NUM_PORTS-1:0]   resp_ack,
  output logic [NUM_PORTS-1:0]   resp_nak,
  output logic [MAP_W-1:0]       resp_result,
  output logic                   ftm_req_valid,
  output logic [MAC_W-1:0]       ftm_req_mac,
  input  logic                   ftm_resp_ack,
  input  logic                   ftm_resp_nak,
  input  logic [MAP_W-1:0]       ftm_resp_result,
  output logic                   timeout_err
);

  localparam int IW = $clog2(NUM_PORTS);

  arb_state_e           state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        g;
  logic [IW-1:0]        g_next;
  logic [IW-1:0]        pick_idx;
  logic [NUM_PORTS-1:0] pick_oh;
  logic                 any_req;
  logic [MAC_W-1:0]     pick_mac;
  logic                 hit;
  logic                 miss;
  logic                 to_hit;
  logic                 drain_done;

  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (pick_oh),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  always_comb begin
    pick_mac = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (pick_oh[i])
        pick_mac = pick_mac | req_mac[16*i +: 16];
  end

  // ack wins when the lookup raises both
  assign hit  = ftm_resp_ack;
  assign miss = ftm_resp_nak & ~ftm_resp_ack;

  assign g_next = (g == IW'(NUM_PORTS - 1)) ? '0 : g + 1'b1;

  // release only after requester and lookup have both let go
  assign drain_done = !req_valid[g] && !ftm_resp_ack && !ftm_resp_nak;

`ifdef HASH_MC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  assign to_hit = (wait_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ARB_ISSUE)
        wait_cnt <= '0;
      else if (state == ARB_WAIT && !to_hit)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == ARB_WAIT && !hit && !miss && to_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
  end
`endif

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state         <= ARB_IDLE;
      rr_ptr        <= '0;
      g             <= '0;
      ftm_req_mac   <= '0;
      ftm_req_valid <= 1'b0;
      resp_ack      <= '0;
      resp_nak      <= '0;
      resp_result   <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (any_req) begin
            g           <= pick_idx;
            ftm_req_mac <= pick_mac;
            state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          ftm_req_valid <= 1'b1;
          state         <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (hit) begin
            resp_result   <= ftm_resp_result;
            resp_ack[g]   <= 1'b1;
            ftm_req_valid <= 1'b0;
            state         <= ARB_DRAIN;
          end else if (miss || to_hit) begin
            resp_nak[g]   <= 1'b1;
            ftm_req_valid <= 1'b0;
            state         <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (!req_valid[g]) begin
            resp_ack[g] <= 1'b0;
            resp_nak[g] <= 1'b0;
          end
          if (drain_done) begin
            rr_ptr <= g_next;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_multicast_arbiter.sv
// Directed bench for hash_multicast_arbiter (NUM_PORTS=4, TIMEOUT_CYCLES=8).
// Lookup handshake is driven by hand from the stimulus sequence.
module tb_hash_multicast_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_mac;
  logic [3:0]  resp_ack;
  logic [3:0]  resp_nak;
  logic [15:0] resp_result;
  logic        ftm_req_valid;
  logic [15:0] ftm_req_mac;
  logic        ftm_resp_ack;
  logic        ftm_resp_nak;
  logic [15:0] ftm_resp_result;
  logic        timeout_err;

  integer passed = 0;
  integer total  = 0;

  always #5 clk = ~clk;

  hash_multicast_arbiter #(
    .NUM_PORTS      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_sys         (clk),
    .rst_sys         (rst_n),
    .req_valid       (req_valid),
    .req_mac         (req_mac),
    .resp_ack        (resp_ack),
    .resp_nak        (resp_nak),
    .resp_result     (resp_result),
    .ftm_req_valid   (ftm_req_valid),
    .ftm_req_mac     (ftm_req_mac),
    .ftm_resp_ack    (ftm_resp_ack),
    .ftm_resp_nak    (ftm_resp_nak),
    .ftm_resp_result (ftm_resp_result),
    .timeout_err     (timeout_err)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_grant(input int p, input logic [15:0] mac);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (ftm_req_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("grant_seen_p%0d", p), {31'd0, seen}, 32'd1);
    chk($sformatf("ftm_mac_p%0d", p), {16'd0, ftm_req_mac}, {16'd0, mac});
  endtask

  task automatic respond(input int p, input logic a, input logic n,
                         input logic [15:0] res, input logic [15:0] exp_res);
    logic [3:0] one;
    one = 4'b0001 << p;
    cyc(2);
    ftm_resp_ack    = a;
    ftm_resp_nak    = n;
    ftm_resp_result = res;
    cyc(1);
    chk($sformatf("resp_ack_p%0d", p), {28'd0, resp_ack},
        {28'd0, (a ? one : 4'b0000)});
    chk($sformatf("resp_nak_p%0d", p), {28'd0, resp_nak},
        {28'd0, ((n && !a) ? one : 4'b0000)});
    chk($sformatf("resp_result_p%0d", p), {16'd0, resp_result},
        {16'd0, exp_res});
    chk($sformatf("ftm_valid_low_p%0d", p), {31'd0, ftm_req_valid}, 32'd0);
  endtask

  task automatic release_port(input int p);
    req_valid[p] = 1'b0;
    ftm_resp_ack = 1'b0;
    ftm_resp_nak = 1'b0;
    cyc(1);
    chk($sformatf("resp_clear_p%0d", p), {28'd0, resp_ack | resp_nak}, 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    cyc(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    req_valid       = '0;
    req_mac         = '0;
    ftm_resp_ack    = 1'b0;
    ftm_resp_nak    = 1'b0;
    ftm_resp_result = '0;
    cyc(2);
    chk("rst_resp_ack", {28'd0, resp_ack}, 32'd0);
    chk("rst_resp_nak", {28'd0, resp_nak}, 32'd0);
    chk("rst_result", {16'd0, resp_result}, 32'd0);
    chk("rst_ftm_valid", {31'd0, ftm_req_valid}, 32'd0);
    chk("rst_ftm_mac", {16'd0, ftm_req_mac}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // single request on port 2, end-to-end latency
    req_mac   = {16'h1111, 16'h0000, 16'h2222, 16'h3333};
    req_valid = 4'b0100;
    cyc(1);
    chk("lat_ftm_valid_c1", {31'd0, ftm_req_valid}, 32'd0);
    cyc(1);
    chk("lat_ftm_valid_c2", {31'd0, ftm_req_valid}, 32'd1);
    chk("lat_ftm_mac", {16'd0, ftm_req_mac}, 32'h0000);
    cyc(2);
    ftm_resp_ack    = 1'b1;
    ftm_resp_result = 16'h0008;
    chk("lat_ack_c4", {28'd0, resp_ack}, 32'd0);
    cyc(1);
    chk("lat_ack_c5", {28'd0, resp_ack}, 32'b0100);
    chk("lat_nak_c5", {28'd0, resp_nak}, 32'd0);
    chk("lat_result", {16'd0, resp_result}, 32'h0008);
    chk("lat_ftm_drop", {31'd0, ftm_req_valid}, 32'd0);
    release_port(2);
    chk("lat_result_kept", {16'd0, resp_result}, 32'h0008);

    // async reset clears result without a clock edge
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", {16'd0, resp_result}, 32'd0);
    cyc(1);
    rst_n = 1'b1;

    // all ports continuously requesting: 0,1,2,3,0
    req_mac   = {16'h1234, 16'h0010, 16'h0003, 16'h0001};
    req_valid = 4'b1111;
    wait_grant(0, 16'h0001);
    respond(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    release_port(0);
    req_valid[0] = 1'b1;
    wait_grant(1, 16'h0003);
    respond(1, 1'b1, 1'b0, 16'h0008, 16'h0008);
    release_port(1);
    req_valid[1] = 1'b1;
    wait_grant(2, 16'h0010);
    respond(2, 1'b1, 1'b0, 16'h000F, 16'h000F);
    release_port(2);
    req_valid[2] = 1'b1;
    wait_grant(3, 16'h1234);
    respond(3, 1'b0, 1'b1, 16'hFFFF, 16'h000F);
    release_port(3);
    req_valid[3] = 1'b1;
    wait_grant(0, 16'h0001);
    respond(0, 1'b1, 1'b0, 16'h00A5, 16'h00A5);
    req_valid = 4'b0000;
    release_port(0);

    // port 1 withdraws during port 0's lookup; port 3 is next
    pulse_reset();
    req_mac   = {16'hCAFE, 16'hBEEF, 16'h0BAD, 16'hF00D};
    req_valid = 4'b0011;
    wait_grant(0, 16'hF00D);
    req_valid[1] = 1'b0;
    respond(0, 1'b1, 1'b0, 16'h0101, 16'h0101);
    release_port(0);
    req_valid[3] = 1'b1;
    wait_grant(3, 16'hCAFE);
    chk("withdrawn_p1_ack", {31'd0, resp_ack[1]}, 32'd0);
    respond(3, 1'b1, 1'b1, 16'h0202, 16'h0202);
    release_port(3);

    // requester holds req_valid after ack; lookup ack also lingers
    req_valid = 4'b0001;
    wait_grant(0, 16'hF00D);
    respond(0, 1'b1, 1'b0, 16'h5A5A, 16'h5A5A);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk($sformatf("hold_ftm_valid_%0d", i), {31'd0, ftm_req_valid}, 32'd0);
      chk($sformatf("hold_resp_%0d", i), {28'd0, resp_ack}, 32'b0001);
    end
    req_valid[0] = 1'b0;
    cyc(1);
    chk("hold_resp_cleared", {28'd0, resp_ack}, 32'd0);
    cyc(2);
    chk("hold_ack_blocks", {31'd0, ftm_req_valid}, 32'd0);
    ftm_resp_ack = 1'b0;
    wait_grant(1, 16'h0BAD);
    respond(1, 1'b0, 1'b1, 16'h7777, 16'h5A5A);
    release_port(1);

    // reset during WAIT, then fresh request on port 0
    req_valid = 4'b0100;
    wait_grant(2, 16'hBEEF);
    rst_n = 1'b0;
    #1;
    chk("midrst_ftm_valid", {31'd0, ftm_req_valid}, 32'd0);
    chk("midrst_ftm_mac", {16'd0, ftm_req_mac}, 32'd0);
    chk("midrst_result", {16'd0, resp_result}, 32'd0);
    chk("midrst_resp", {28'd0, resp_ack | resp_nak}, 32'd0);
    req_valid = 4'b0000;
    cyc(1);
    rst_n = 1'b1;
    req_valid[0] = 1'b1;
    wait_grant(0, 16'hF00D);
    respond(0, 1'b1, 1'b0, 16'h0033, 16'h0033);
    release_port(0);

`ifdef HASH_MC_ARB_TIMEOUT_EN
    // silent lookup: nak and sticky error 9 cycles after WAIT entry
    req_valid = 4'b0010;
    wait_grant(1, 16'h0BAD);
    cyc(8);
    chk("to_nak_early", {28'd0, resp_nak}, 32'd0);
    chk("to_err_early", {31'd0, timeout_err}, 32'd0);
    cyc(1);
    chk("to_nak", {28'd0, resp_nak}, 32'b0010);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_ftm_low", {31'd0, ftm_req_valid}, 32'd0);
    chk("to_result", {16'd0, resp_result}, 32'h0033);
    release_port(1);
    chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
`else
    chk("timeout_err_tied", {31'd0, timeout_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
